// File: rtl/spi_pkg.sv
// Shared widths and mode encodings for the SPI serial data path.
package spi_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_DATA_W);

  localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
  localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

  localparam logic DORD_MSB = 1'b0;
  localparam logic DORD_LSB = 1'b1;

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for the SPI frame: synchronous clear, enable, wraps at DATA_W-1.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_shifter.sv
// SPI data path: SPDR tx/rx buffers, shift register, serial out and write-collision flag.
module spi_shifter
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Shifter_en,
  input  logic              counter_enable,
  input  logic              SPDR_rd_en,
  input  logic              SPDR_wr_en,
  input  logic              sck_lead,
  input  logic              sck_trail,
  input  logic              CPHA,
  input  logic              DORD,
  input  logic              sdi,
  output logic              sdo,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              wcol_clr,
  output logic [DATA_W-1:0] spdr_rdata,
  output logic [CNT_W-1:0]  counter,
  output logic              WCOL
);

  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] rx_buf;
  logic [DATA_W-1:0] shift_reg;

  logic              wr_ok;
  logic              wr_reject;
  logic [DATA_W-1:0] preload_val;
  logic              sample_strobe;
  logic              drive_strobe;
  logic              sample_edge;
  logic              drive_edge;

  function automatic logic drive_bit(input logic [DATA_W-1:0] v, input logic dord);
    return (dord == DORD_LSB) ? v[0] : v[DATA_W-1];
  endfunction

  // Edge roles swap with CPHA; a coincident drive strobe is dropped in favour of sampling.
  always_comb begin
    wr_ok         = cpu_wr & ~Shifter_en;
    wr_reject     = cpu_wr & Shifter_en;
    preload_val   = wr_ok ? cpu_wdata : tx_buf;
    sample_strobe = (CPHA == CPHA_SAMPLE_TRAIL) ? sck_trail : sck_lead;
    drive_strobe  = (CPHA == CPHA_SAMPLE_TRAIL) ? sck_lead : sck_trail;
    sample_edge   = Shifter_en & ~SPDR_rd_en & sample_strobe;
    drive_edge    = Shifter_en & ~SPDR_rd_en & drive_strobe & ~sample_strobe;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf <= '0;
      WCOL   <= 1'b0;
    end else begin
      if (wr_ok) begin
        tx_buf <= cpu_wdata;
      end
      if (wr_reject) begin
        WCOL <= 1'b1;
      end else if (wr_ok || wcol_clr) begin
        WCOL <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      sdo       <= 1'b0;
    end else if (SPDR_rd_en) begin
      shift_reg <= preload_val;
      sdo       <= drive_bit(preload_val, DORD);
    end else begin
      if (sample_edge) begin
        shift_reg <= (DORD == DORD_LSB) ? {sdi, shift_reg[DATA_W-1:1]}
                                        : {shift_reg[DATA_W-2:0], sdi};
      end
      if (drive_edge) begin
        sdo <= drive_bit(shift_reg, DORD);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf <= '0;
    end else if (SPDR_wr_en) begin
      rx_buf <= shift_reg;
    end
  end

  assign spdr_rdata = rx_buf;

  spi_bit_counter #(
    .DATA_W (DATA_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (SPDR_rd_en),
    .en    (sample_edge & counter_enable),
    .count (counter)
  );

endmodule

// File: tb/tb_spi_shifter.sv
// Directed self-checking bench for spi_shifter.
module tb_spi_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       Shifter_en;
  logic       counter_enable;
  logic       SPDR_rd_en;
  logic       SPDR_wr_en;
  logic       sck_lead;
  logic       sck_trail;
  logic       CPHA;
  logic       DORD;
  logic       sdi;
  logic       sdo;
  logic       cpu_wr;
  logic [7:0] cpu_wdata;
  logic       wcol_clr;
  logic [7:0] spdr_rdata;
  logic [2:0] counter;
  logic       WCOL;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_shifter dut (
    .clk            (clk),
    .rst            (rst),
    .Shifter_en     (Shifter_en),
    .counter_enable (counter_enable),
    .SPDR_rd_en     (SPDR_rd_en),
    .SPDR_wr_en     (SPDR_wr_en),
    .sck_lead       (sck_lead),
    .sck_trail      (sck_trail),
    .CPHA           (CPHA),
    .DORD           (DORD),
    .sdi            (sdi),
    .sdo            (sdo),
    .cpu_wr         (cpu_wr),
    .cpu_wdata      (cpu_wdata),
    .wcol_clr       (wcol_clr),
    .spdr_rdata     (spdr_rdata),
    .counter        (counter),
    .WCOL           (WCOL)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    cpu_wr = 1'b1; cpu_wdata = d; tick(); cpu_wr = 1'b0;
  endtask

  task automatic preload();
    SPDR_rd_en = 1'b1; tick(); SPDR_rd_en = 1'b0;
  endtask

  task automatic update();
    SPDR_wr_en = 1'b1; tick(); SPDR_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (sdo !== 1'b0 || counter !== 3'd0 || spdr_rdata !== 8'h00 || WCOL !== 1'b0) begin
      errors++;
      $display("FAIL reset: sdo=%b counter=%0d rdata=%h WCOL=%b, want 0 0 00 0", sdo, counter, spdr_rdata, WCOL);
    end
  endtask

  task automatic test_msb_cpha0();
    logic [7:0] tx;
    logic [7:0] rx;
    tx = 8'hA5; rx = 8'h3C;
    DORD = 1'b0; CPHA = 1'b0; Shifter_en = 1'b0;
    cpu_write(tx);
    preload();
    checks++;
    if (sdo !== 1'b1 || counter !== 3'd0) begin
      errors++;
      $display("FAIL msb_preload: sdo=%b counter=%0d, want 1 0", sdo, counter);
    end
    Shifter_en = 1'b1; counter_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sdi = rx[7-i];
      sck_lead = 1'b1; tick(); sck_lead = 1'b0;
      checks++;
      if (counter !== 3'((i + 1) % 8)) begin
        errors++;
        $display("FAIL msb_counter[%0d]: got %0d want %0d", i, counter, (i + 1) % 8);
      end
      sck_trail = 1'b1; tick(); sck_trail = 1'b0;
      if (i < 7) begin
        checks++;
        if (sdo !== tx[6-i]) begin
          errors++;
          $display("FAIL msb_sdo[%0d]: got %b want %b", i + 1, sdo, tx[6-i]);
        end
      end
    end
    Shifter_en = 1'b0;
    update();
    checks++;
    if (spdr_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL msb_rdata: got %h want 3c", spdr_rdata);
    end
  endtask

  task automatic test_lsb_cpha1();
    logic [7:0] tx;
    logic [7:0] rx;
    tx = 8'h81; rx = 8'h96;
    DORD = 1'b1; CPHA = 1'b1; Shifter_en = 1'b0;
    cpu_write(tx);
    preload();
    Shifter_en = 1'b1; counter_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sck_lead = 1'b1; tick(); sck_lead = 1'b0;
      checks++;
      if (sdo !== tx[i]) begin
        errors++;
        $display("FAIL lsb_sdo[%0d]: got %b want %b", i, sdo, tx[i]);
      end
      sdi = rx[i];
      sck_trail = 1'b1; tick(); sck_trail = 1'b0;
      checks++;
      if (counter !== 3'((i + 1) % 8)) begin
        errors++;
        $display("FAIL lsb_counter[%0d]: got %0d want %0d", i, counter, (i + 1) % 8);
      end
    end
    Shifter_en = 1'b0;
    update();
    checks++;
    if (spdr_rdata !== 8'h96) begin
      errors++;
      $display("FAIL lsb_rdata: got %h want 96", spdr_rdata);
    end
  endtask

  task automatic test_collision();
    DORD = 1'b0; CPHA = 1'b0;
    Shifter_en = 1'b1;
    cpu_write(8'h55);
    checks++;
    if (WCOL !== 1'b1) begin
      errors++;
      $display("FAIL wcol_set: got %b want 1", WCOL);
    end
    Shifter_en = 1'b0;
    preload(); update();
    checks++;
    if (spdr_rdata !== 8'h81) begin
      errors++;
      $display("FAIL wcol_txbuf_kept: got %h want 81", spdr_rdata);
    end
    cpu_write(8'h11);
    checks++;
    if (WCOL !== 1'b0) begin
      errors++;
      $display("FAIL wcol_clr_by_write: got %b want 0", WCOL);
    end
    preload(); update();
    checks++;
    if (spdr_rdata !== 8'h11) begin
      errors++;
      $display("FAIL wcol_txbuf_new: got %h want 11", spdr_rdata);
    end
    Shifter_en = 1'b1; wcol_clr = 1'b1;
    cpu_write(8'h22);
    wcol_clr = 1'b0;
    checks++;
    if (WCOL !== 1'b1) begin
      errors++;
      $display("FAIL wcol_set_wins: got %b want 1", WCOL);
    end
    Shifter_en = 1'b0;
    wcol_clr = 1'b1; tick(); wcol_clr = 1'b0;
    checks++;
    if (WCOL !== 1'b0) begin
      errors++;
      $display("FAIL wcol_clr: got %b want 0", WCOL);
    end
  endtask

  task automatic test_preload_bypass();
    DORD = 1'b0; Shifter_en = 1'b0;
    cpu_wr = 1'b1; cpu_wdata = 8'h7E; SPDR_rd_en = 1'b1;
    tick();
    cpu_wr = 1'b0; SPDR_rd_en = 1'b0;
    checks++;
    if (sdo !== 1'b0) begin
      errors++;
      $display("FAIL bypass_sdo: got %b want 0", sdo);
    end
    update();
    checks++;
    if (spdr_rdata !== 8'h7E) begin
      errors++;
      $display("FAIL bypass_shift_reg: got %h want 7e", spdr_rdata);
    end
  endtask

  task automatic test_freeze_and_reset();
    DORD = 1'b0; CPHA = 1'b0;
    preload();
    Shifter_en = 1'b1; counter_enable = 1'b1; sdi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sck_lead = 1'b1; tick(); sck_lead = 1'b0;
      sck_trail = 1'b1; tick(); sck_trail = 1'b0;
    end
    Shifter_en = 1'b0; sdi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sck_lead = (i % 2 == 0); sck_trail = (i % 2 == 1);
      tick();
    end
    sck_lead = 1'b0; sck_trail = 1'b0;
    checks++;
    if (counter !== 3'd3 || sdo !== 1'b1) begin
      errors++;
      $display("FAIL freeze: counter=%0d sdo=%b, want 3 1", counter, sdo);
    end
    update();
    checks++;
    if (spdr_rdata !== 8'hF7) begin
      errors++;
      $display("FAIL freeze_shift_reg: got %h want f7", spdr_rdata);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (counter !== 3'd0 || sdo !== 1'b0 || spdr_rdata !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: counter=%0d sdo=%b rdata=%h, want 0 0 00", counter, sdo, spdr_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous_strobes();
    DORD = 1'b0; CPHA = 1'b0; Shifter_en = 1'b0;
    cpu_write(8'hA0);
    preload();
    Shifter_en = 1'b1; counter_enable = 1'b1; sdi = 1'b0;
    sck_lead = 1'b1; tick(); sck_lead = 1'b0;
    sck_lead = 1'b1; sck_trail = 1'b1; tick(); sck_lead = 1'b0; sck_trail = 1'b0;
    checks++;
    if (counter !== 3'd2 || sdo !== 1'b1) begin
      errors++;
      $display("FAIL both_strobes: counter=%0d sdo=%b, want 2 1", counter, sdo);
    end
    counter_enable = 1'b0;
    sck_lead = 1'b1; tick(); sck_lead = 1'b0;
    checks++;
    if (counter !== 3'd2) begin
      errors++;
      $display("FAIL counter_enable_low: got %0d want 2", counter);
    end
    Shifter_en = 1'b0;
    update();
    checks++;
    if (spdr_rdata !== 8'h00) begin
      errors++;
      $display("FAIL both_strobes_shift: got %h want 00", spdr_rdata);
    end
  endtask

  initial begin
    rst = 1'b0;
    Shifter_en = 1'b0; counter_enable = 1'b0; SPDR_rd_en = 1'b0; SPDR_wr_en = 1'b0;
    sck_lead = 1'b0; sck_trail = 1'b0; CPHA = 1'b0; DORD = 1'b0; sdi = 1'b0;
    cpu_wr = 1'b0; cpu_wdata = 8'h00; wcol_clr = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_msb_cpha0();
    test_lsb_cpha1();
    test_collision();
    test_preload_bypass();
    test_freeze_and_reset();
    test_simultaneous_strobes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
